// File: rtl/rbt_s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbt_s_pkg
// Description : Shared constants and types for the RBT-S transport-layer
//               parser/deparser pipeline. Holds the PHV container indices,
//               the packet-property flag bits, the header field offsets
//               (counted in bits from the header MSB) and the per-frame
//               status flags carried through the output register slice.
// Revision    : 1.0 - initial release
// ============================================================================
package rbt_s_pkg;

    // PHV container indices
    localparam int PKT_PROPERTY_NO = 0;     // byte container holding the frame flags
    localparam int RSIP_NO         = 5;     // first of four 32-bit words carrying RSIP
    localparam int PKT_RPN_NO      = 9;     // 32-bit word carrying RPN

    // Flag bits inside the packet-property byte
    localparam int DAT    = 2;
    localparam int RFLAG  = 1;
    localparam int XTRANS = 7;

    // Header field positions, in bits from the header MSB
    localparam int RSIP_OFFSET = 48;
    localparam int RSIP_WIDTH  = 128;
    localparam int RPN_OFFSET  = 176;
    localparam int RPN_WIDTH   = 32;

    // Shortest header (bytes) that still covers the RPN field
    localparam int MIN_XTRANS_LEN = 26;

    // Per-frame status carried alongside the frame through the slice
    typedef struct packed {
        logic rewritten;    // RSIP/RPN were written back into the header
        logic len_err;      // rewrite wanted but header too short
    } rbt_s_flags_t;

endpackage : rbt_s_pkg
`default_nettype wire

// File: rtl/rbt_s_hdr_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rbt_s_hdr_skid_buffer
// Description : Generic 2-entry register slice (output register + skid
//               register) for header/PHV/length/flag frames. The upstream
//               ready is driven purely from a flop (~skid_valid), so no
//               combinational path runs from out_ready to in_ready.
// Ports       : clk, rst           clock, synchronous active-high reset
//               in_valid/in_ready  upstream handshake (in_ready registered)
//               in_data/phv/len/flag   frame payload
//               out_valid/out_ready    downstream handshake
//               out_data/phv/len/flag  presented frame, stable until accepted
//               out_new            high in the first cycle a frame is presented
// Revision    : 1.0 - initial release
// ============================================================================
module rbt_s_hdr_skid_buffer #(
    parameter int DATA_W = 2048,
    parameter int PHV_W  = 408,
    parameter int LEN_W  = 16,
    parameter int FLAG_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PHV_W-1:0]  in_phv,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [FLAG_W-1:0] in_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PHV_W-1:0]  out_phv,
    output logic [LEN_W-1:0]  out_len,
    output logic [FLAG_W-1:0] out_flag,
    output logic              out_new
);

    localparam int PAY_W = DATA_W + PHV_W + LEN_W + FLAG_W;

    logic             out_valid_q, out_valid_d;
    logic [PAY_W-1:0] out_pay_q,   out_pay_d;
    logic             skid_valid_q, skid_valid_d;
    logic [PAY_W-1:0] skid_pay_q,  skid_pay_d;
    logic             ready_q,     ready_d;
    logic             out_new_q,   out_new_d;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [PAY_W-1:0] w_in_pay;

    assign w_in_pay   = {in_data, in_phv, in_len, in_flag};
    assign w_in_fire  = in_valid & ready_q;
    assign w_out_fire = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pay_d    = out_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;
        out_new_d    = 1'b0;
        if (!out_valid_q || w_out_fire) begin
            // Output register free this cycle: the skid entry is older than
            // anything arriving now, so it always goes first. A full skid
            // implies ready was low, so no input can fire in that case.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pay_d    = skid_pay_q;
                skid_valid_d = 1'b0;
                out_new_d    = 1'b1;
            end else if (w_in_fire) begin
                out_valid_d = 1'b1;
                out_pay_d   = w_in_pay;
                out_new_d   = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            // Output stalled: park the new frame in the skid register.
            skid_valid_d = 1'b1;
            skid_pay_d   = w_in_pay;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_pay_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
            ready_q      <= 1'b1;
            out_new_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pay_q    <= out_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
            ready_q      <= ready_d;
            out_new_q    <= out_new_d;
        end
    end

    // Held low while reset is applied; otherwise a pure flop output.
    assign in_ready  = ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign {out_data, out_phv, out_len, out_flag} = out_pay_q;
    assign out_new   = out_new_q;

endmodule : rbt_s_hdr_skid_buffer
`default_nettype wire

// File: rtl/rbt_s_transport_layer_deparser.sv
`default_nettype none
// ============================================================================
// Module      : rbt_s_transport_layer_deparser
// Description : Egress transport-layer deparser. For data frames with RFLAG
//               and XTRANS set, writes PHV words 5..8 (RSIP) and word 9 (RPN)
//               back into header bits 48..175 / 176..207 (from the MSB).
//               Too-short headers pass unmodified and raise a one-cycle
//               out_len_err. Output goes through a 2-entry register slice.
// Ports       : clk, rst (sync, active-high); in_proto_hdr_* upstream frame
//               and handshake; out_proto_hdr_* downstream frame and
//               handshake; out_len_err rewrite-suppressed pulse.
// Option      : RBT_S_DEPARSER_STATS_EN adds stat_rewrite_cnt,
//               stat_pass_cnt and stat_len_err_cnt (counted at output
//               acceptance, wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module rbt_s_transport_layer_deparser
    import rbt_s_pkg::*;
#(
    parameter int HEADER_WIDTH = 2048,
    parameter int PHV_WIDTH    = 408,
    parameter int PHV_B_NUM    = 7,
    parameter int PHV_H_NUM    = 2,
    parameter int PHV_W_NUM    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_proto_hdr_valid,
    output logic                    in_proto_hdr_ready,
    input  logic [15:0]             in_proto_hdr_length,
    input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
    input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
    output logic                    out_proto_hdr_valid,
    input  logic                    out_proto_hdr_ready,
    output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
    output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
    output logic [15:0]             out_proto_hdr_length,
    output logic                    out_len_err
`ifdef RBT_S_DEPARSER_STATS_EN
    ,
    output logic [31:0]             stat_rewrite_cnt,
    output logic [31:0]             stat_pass_cnt,
    output logic [15:0]             stat_len_err_cnt
`endif
);

    // 32-bit containers start after all byte and half-word containers.
    localparam int W_BASE   = PHV_B_NUM * 8 + PHV_H_NUM * 16;
    localparam int RSIP_LSB = W_BASE + 32 * RSIP_NO;
    localparam int RPN_LSB  = W_BASE + 32 * PKT_RPN_NO;

    if (HEADER_WIDTH % 8 != 0) begin : g_hdr_width_check
        $error("HEADER_WIDTH must be a multiple of 8");
    end
    if (PHV_W_NUM <= PKT_RPN_NO || PHV_WIDTH < W_BASE + 32 * PHV_W_NUM) begin : g_phv_width_check
        $error("PHV too small for the RSIP/RPN word containers");
    end

    logic [7:0]              w_prop;
    logic                    w_cond;
    logic                    w_short;
    logic [HEADER_WIDTH-1:0] w_data;
    rbt_s_flags_t            w_flags;
    rbt_s_flags_t            w_out_flags;
    logic                    w_out_new;

    assign w_prop  = in_proto_hdr_phv[8*PKT_PROPERTY_NO +: 8];
    assign w_cond  = w_prop[DAT] & w_prop[RFLAG] & w_prop[XTRANS];
    assign w_short = in_proto_hdr_length < 16'(MIN_XTRANS_LEN);

    always_comb begin
        w_data  = in_proto_hdr_data;
        w_flags = '0;
        if (w_cond) begin
            if (w_short) begin
                w_flags.len_err = 1'b1;
            end else begin
                w_flags.rewritten = 1'b1;
                // Words 5..8 are contiguous with word 8 highest, which is
                // exactly the {w8,w7,w6,w5} order the header wants.
                w_data[HEADER_WIDTH-1-RSIP_OFFSET -: RSIP_WIDTH] =
                    in_proto_hdr_phv[RSIP_LSB +: RSIP_WIDTH];
                w_data[HEADER_WIDTH-1-RPN_OFFSET -: RPN_WIDTH] =
                    in_proto_hdr_phv[RPN_LSB +: RPN_WIDTH];
            end
        end
    end

    rbt_s_hdr_skid_buffer #(
        .DATA_W (HEADER_WIDTH),
        .PHV_W  (PHV_WIDTH),
        .LEN_W  (16),
        .FLAG_W ($bits(rbt_s_flags_t))
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_proto_hdr_valid),
        .in_ready  (in_proto_hdr_ready),
        .in_data   (w_data),
        .in_phv    (in_proto_hdr_phv),
        .in_len    (in_proto_hdr_length),
        .in_flag   (w_flags),
        .out_valid (out_proto_hdr_valid),
        .out_ready (out_proto_hdr_ready),
        .out_data  (out_proto_hdr_data),
        .out_phv   (out_proto_hdr_phv),
        .out_len   (out_proto_hdr_length),
        .out_flag  (w_out_flags),
        .out_new   (w_out_new)
    );

    // Only the first presentation cycle reports the error, even if stalled.
    assign out_len_err = w_out_new & w_out_flags.len_err;

`ifdef RBT_S_DEPARSER_STATS_EN
    logic        w_out_fire;
    logic [31:0] stat_rewrite_cnt_q, stat_rewrite_cnt_d;
    logic [31:0] stat_pass_cnt_q,    stat_pass_cnt_d;
    logic [15:0] stat_len_err_cnt_q, stat_len_err_cnt_d;

    assign w_out_fire = out_proto_hdr_valid & out_proto_hdr_ready;

    always_comb begin
        stat_rewrite_cnt_d = stat_rewrite_cnt_q;
        stat_pass_cnt_d    = stat_pass_cnt_q;
        stat_len_err_cnt_d = stat_len_err_cnt_q;
        if (w_out_fire) begin
            if (w_out_flags.rewritten) begin
                stat_rewrite_cnt_d = stat_rewrite_cnt_q + 32'd1;
            end else begin
                stat_pass_cnt_d = stat_pass_cnt_q + 32'd1;
            end
            if (w_out_flags.len_err) begin
                stat_len_err_cnt_d = stat_len_err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rewrite_cnt_q <= '0;
            stat_pass_cnt_q    <= '0;
            stat_len_err_cnt_q <= '0;
        end else begin
            stat_rewrite_cnt_q <= stat_rewrite_cnt_d;
            stat_pass_cnt_q    <= stat_pass_cnt_d;
            stat_len_err_cnt_q <= stat_len_err_cnt_d;
        end
    end

    assign stat_rewrite_cnt = stat_rewrite_cnt_q;
    assign stat_pass_cnt    = stat_pass_cnt_q;
    assign stat_len_err_cnt = stat_len_err_cnt_q;
`endif

endmodule : rbt_s_transport_layer_deparser
`default_nettype wire
